// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with valid/ready output, framing-error and overrun pulses
module uart_receiver #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] bus,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bitidx, bitidx_n;
  logic [7:0] shift, shift_n;
  logic rxs, done, ferr;
  assign rxs = sync[SYNC_STAGES-1];
  assign busy = state != IDLE;
  // Counting restarts at mid start bit, so every later sample lands mid-bit.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bitidx_n = bitidx;
    shift_n = shift;
    done = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        bitidx_n = '0;
        if (!rxs) state_n = START;
      end
      START: if (cnt == CW'(HALF - 1)) begin
        cnt_n = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_n = '0;
        shift_n[bitidx] = rxs;
        bitidx_n = bitidx + 3'd1;
        if (bitidx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt_n = '0;
        done = rxs;
        ferr = !rxs;
        state_n = rxs ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sync <= '1;
      cnt <= '0;
      bitidx <= '0;
      shift <= '0;
      bus <= '0;
      valid <= 1'b0;
      framing_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      sync <= {sync[SYNC_STAGES-2:0], rx};
      cnt <= cnt_n;
      bitidx <= bitidx_n;
      shift <= shift_n;
      if (done) bus <= shift;
      valid <= done | (valid & ~ready);
      framing_err <= ferr;
      overrun <= done & valid & ~ready;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at a reduced bit period
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int CPB = 32;
  localparam int SYNC = 2;
  localparam int LAT = SYNC + CPB / 2 + 9 * CPB;
  logic clk, rst, rx, ready, valid, framing_err, overrun, busy;
  logic [7:0] bus;
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0, fe_cnt = 0, ov_cnt = 0, rx_cnt = 0;

  uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus(bus), .valid(valid), .ready(ready),
    .framing_err(framing_err), .overrun(overrun), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [7:0] e;
    if (framing_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (valid && ready) begin
      rx_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got bus=%h, expected no byte", bus);
      end else begin
        e = exp_q.pop_front();
        if (bus !== e) begin
          errors++;
          $display("FAIL sb_byte: got %h, expected %h", bus, e);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
    rx = 0;
    wait_cyc(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(bc);
    end
    rx = stop;
    wait_cyc(bc);
  endtask

  task automatic test_reset;
    rst = 0; rx = 1; ready = 0;
    wait_cyc(4);
    checks++;
    if ({bus, valid, framing_err, overrun, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got bus=%h v=%b fe=%b ov=%b busy=%b, expected all 0", bus, valid, framing_err, overrun, busy);
    end
    rst = 1;
    wait_cyc(4);
  endtask

  task automatic test_single;
    int lat = 0;
    int fe0 = fe_cnt;
    ready = 0;
    exp_q.push_back(8'h48);
    fork send_frame(8'h48, 1, CPB); join_none
    while (!valid && lat < LAT + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected %0d +-1", lat, LAT);
    end
    checks++;
    if (bus !== 8'h48) begin
      errors++;
      $display("FAIL single_bus: got %h, expected 48", bus);
    end
    wait_cyc(CPB);
    checks++;
    if (valid !== 1'b1 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL single_hold: got valid=%b fe=%0d, expected valid=1 fe=0", valid, fe_cnt - fe0);
    end
    ready = 1;
    wait_cyc(1);
    ready = 0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_clear: got valid=%b, expected 0", valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] msg[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    int r0 = rx_cnt, o0 = ov_cnt, f0 = fe_cnt;
    ready = 1;
    foreach (msg[i]) begin
      exp_q.push_back(msg[i]);
      send_frame(msg[i], 1, CPB);
    end
    wait_cyc(CPB);
    checks++;
    if (rx_cnt - r0 != 13 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d bytes (%0d pending), expected 13 (0 pending)", rx_cnt - r0, exp_q.size());
    end
    checks++;
    if (ov_cnt != o0 || fe_cnt != f0) begin
      errors++;
      $display("FAIL stream_flags: got ov=%0d fe=%0d, expected 0 0", ov_cnt - o0, fe_cnt - f0);
    end
  endtask

  task automatic test_glitch;
    int r0 = rx_cnt, f0 = fe_cnt;
    ready = 1;
    rx = 0;
    wait_cyc(CPB / 2);
    rx = 1;
    wait_cyc(2 * CPB);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || fe_cnt != f0 || rx_cnt != r0) begin
      errors++;
      $display("FAIL glitch: got busy=%b valid=%b fe=%0d bytes=%0d, expected all 0", busy, valid, fe_cnt - f0, rx_cnt - r0);
    end
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1, CPB);
    wait_cyc(CPB);
    checks++;
    if (rx_cnt - r0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_next: got %0d bytes, expected 1", rx_cnt - r0);
    end
  endtask

  task automatic test_framing;
    int r0 = rx_cnt, f0 = fe_cnt;
    ready = 1;
    send_frame(8'h55, 0, CPB);
    wait_cyc(5 * CPB);
    checks++;
    if (fe_cnt - f0 != 1 || valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL framing_break: got fe=%0d valid=%b busy=%b, expected 1 0 1", fe_cnt - f0, valid, busy);
    end
    rx = 1;
    wait_cyc(CPB);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1, CPB);
    wait_cyc(CPB);
    checks++;
    if (rx_cnt - r0 != 1 || fe_cnt - f0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL framing_next: got bytes=%0d fe=%0d, expected 1 1", rx_cnt - r0, fe_cnt - f0);
    end
  endtask

  task automatic test_overrun;
    int o0 = ov_cnt;
    ready = 0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1, CPB);
    checks++;
    if (ov_cnt != o0) begin
      errors++;
      $display("FAIL overrun_first: got %0d pulses, expected 0", ov_cnt - o0);
    end
    send_frame(8'h22, 1, CPB);
    wait_cyc(CPB);
    checks++;
    if (ov_cnt - o0 != 1 || bus !== 8'h22 || valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun: got ov=%0d bus=%h valid=%b, expected 1 22 1", ov_cnt - o0, bus, valid);
    end
    void'(exp_q.pop_front());
    ready = 1;
    wait_cyc(2);
    checks++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_drain: got valid=%b pending=%0d, expected 0 0", valid, exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    int r0 = rx_cnt;
    ready = 1;
    fork
      begin
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #2 rst = 0;
        #1;
        checks++;
        if ({bus, valid, framing_err, overrun, busy} !== 12'h000) begin
          errors++;
          $display("FAIL mid_reset: got bus=%h v=%b fe=%b ov=%b busy=%b, expected all 0", bus, valid, framing_err, overrun, busy);
        end
      end
    join_none
    send_frame(8'h6F, 1, CPB);
    wait_cyc(4);
    rst = 1;
    wait_cyc(4);
    exp_q.push_back(8'h6F);
    send_frame(8'h6F, 1, CPB);
    wait_cyc(CPB);
    checks++;
    if (rx_cnt - r0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_next: got %0d bytes, expected 1", rx_cnt - r0);
    end
  endtask

  task automatic test_tolerance;
    int r0 = rx_cnt;
    ready = 1;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1, CPB - 1);
    exp_q.push_back(8'h69);
    send_frame(8'h69, 1, CPB + 1);
    wait_cyc(CPB);
    checks++;
    if (rx_cnt - r0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tolerance: got %0d bytes, expected 2", rx_cnt - r0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_overrun;
    test_mid_reset;
    test_tolerance;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
